// File: rtl/evt_word_assembler.sv
// evt_word_assembler: packs received UART bytes into event words, buffers them
// in a first-word-fall-through FIFO and counts words lost to overflow or timeout.
module evt_word_assembler #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 12000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    output logic [8*BYTES_PER_WORD-1:0]         word_data,
    output logic                                word_valid,
    input  logic                                word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic [CNT_W-1:0]                    overflow_cnt,
    output logic [CNT_W-1:0]                    timeout_cnt,
    output logic                                drop_pulse
);

    localparam int unsigned WORD_W   = 8 * BYTES_PER_WORD;
    localparam int unsigned IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned LAST_IDX = BYTES_PER_WORD - 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W    = AW + 1;
    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    byte_idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [TO_W-1:0]     idle_cnt;
    logic [TO_W-1:0]     idle_nxt;
    logic [WORD_W-1:0]   word_buf;
    logic [WORD_W-1:0]   buf_nxt;
    logic [WORD_W-1:0]   asm_word_c;
    logic                complete_c;
    logic                timeout_c;

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_nxt;
    logic [PTR_W-1:0]    rd_nxt;
    logic                full_c;
    logic                pop_c;
    logic                push_c;
    logic                ovf_c;

    // Assembler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, byte placement, completion and inter-byte timeout
    always_comb begin
        state_nxt  = state;
        idx_nxt    = byte_idx;
        idle_nxt   = idle_cnt;
        buf_nxt    = word_buf;
        asm_word_c = word_buf;
        complete_c = 1'b0;
        timeout_c  = 1'b0;

        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                asm_word_c[((MSB_FIRST != 0) ? (WORD_W - 8 - 8 * k) : (8 * k)) +: 8] = rx_data;
            end
        end

        if (rx_valid) begin
            // A byte always wins over a timeout firing in the same cycle
            idle_nxt = '0;
            if (byte_idx == IDX_W'(LAST_IDX)) begin
                complete_c = 1'b1;
                state_nxt  = IDLE;
                idx_nxt    = '0;
                buf_nxt    = '0;
            end else begin
                state_nxt  = ASSEMBLE;
                idx_nxt    = byte_idx + IDX_W'(1);
                buf_nxt    = asm_word_c;
            end
        end else if (state == ASSEMBLE) begin
            if ((TIMEOUT_CYCLES != 0) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
                timeout_c = 1'b1;
                state_nxt = IDLE;
                idx_nxt   = '0;
                idle_nxt  = '0;
                buf_nxt   = '0;
            end else begin
                idle_nxt  = idle_cnt + TO_W'(1);
            end
        end
    end

    // Assembler datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            idle_cnt <= '0;
            word_buf <= '0;
        end else begin
            byte_idx <= idx_nxt;
            idle_cnt <= idle_nxt;
            word_buf <= buf_nxt;
        end
    end

    // FIFO control: a pop in the completing cycle makes room for the new word
    always_comb begin
        full_c = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop_c  = word_valid && word_ready;
        push_c = complete_c && (!full_c || pop_c);
        ovf_c  = complete_c && full_c && !pop_c;
        wr_nxt = push_c ? (wr_ptr + PTR_W'(1)) : wr_ptr;
        rd_nxt = pop_c  ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= asm_word_c;
        end
    end

    // Pointers, registered head word/flags and saturating drop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            word_valid   <= 1'b0;
            word_data    <= '0;
            overflow_cnt <= '0;
            timeout_cnt  <= '0;
            drop_pulse   <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            fifo_level <= LVL_W'(wr_nxt - rd_nxt);
            word_valid <= (wr_nxt != rd_nxt);
            // New head is the word being pushed when it lands at the read slot
            if (wr_nxt == rd_nxt) begin
                word_data <= '0;
            end else if (push_c && (rd_nxt == wr_ptr)) begin
                word_data <= asm_word_c;
            end else begin
                word_data <= mem[rd_nxt[AW-1:0]];
            end
            if (ovf_c && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            end
            if (timeout_c && (timeout_cnt != '1)) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
            drop_pulse <= ovf_c || timeout_c;
        end
    end

endmodule
